// File: rtl/dest_route_sequencer.sv
// Routes one write transfer at a time to the RF, MEM or IMM destination.
// It also drives the demux select/data lines and the destination strobe or memory handshake.
module dest_route_sequencer #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DEMUX_SELECT_BITS = 2,
  parameter int unsigned ADDR_WIDTH        = 4,
  parameter int unsigned MEM_TIMEOUT       = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DEMUX_SELECT_BITS-1:0] in_dest,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  output logic [DEMUX_SELECT_BITS-1:0] demux_select,
  output logic [DATA_WIDTH-1:0]        demux_data,
  output logic                         rf_we,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic                         imm_load,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int unsigned CntWidth = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MEM_TIMEOUT - 1);

  localparam logic [DEMUX_SELECT_BITS-1:0] SelRf  = '0;
  localparam logic [DEMUX_SELECT_BITS-1:0] SelMem = DEMUX_SELECT_BITS'(1);
  localparam logic [DEMUX_SELECT_BITS-1:0] SelImm = DEMUX_SELECT_BITS'(2);

  typedef enum logic [1:0] {StIdle, StRfWr, StImmLd, StMemReq} state_e;

  state_e              state;
  logic [CntWidth-1:0] wait_cnt;

  assign in_ready = (state == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      wait_cnt     <= '0;
      demux_select <= '0;
      demux_data   <= '0;
      rf_waddr     <= '0;
      mem_addr     <= '0;
      rf_we        <= 1'b0;
      imm_load     <= 1'b0;
      mem_req      <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      imm_load <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            demux_data  <= in_data;
            rf_waddr    <= in_addr;
            mem_addr    <= in_addr;
            timeout_err <= 1'b0;
            if (in_dest == SelMem) begin
              demux_select <= SelMem;
              mem_req      <= 1'b1;
              wait_cnt     <= '0;
              state        <= StMemReq;
            end else if (in_dest == SelImm) begin
              demux_select <= SelImm;
              imm_load     <= 1'b1;
              done         <= 1'b1;
              state        <= StImmLd;
            end else begin
              // The reserved code is routed as RF.
              demux_select <= SelRf;
              rf_we        <= 1'b1;
              done         <= 1'b1;
              state        <= StRfWr;
            end
          end
        end
        StRfWr, StImmLd: state <= StIdle;
        StMemReq: begin
          // An ack on the final wait cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= StIdle;
          end else if (wait_cnt == LastCnt) begin
            mem_req     <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            state       <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + CntWidth'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
